// File: rtl/multi_approach_signal_controller.sv
// N_APP-approach round-robin junction controller with an all-walk pedestrian phase and prioritised emergency preemption.
// Optional build macro PED_CALL_EN adds a ped_call input so the pedestrian phase runs only when it has been requested.
module multi_approach_signal_controller #(
  parameter int N_APP    = 2,
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 5,
  parameter int T_CLEAR  = 2,
  parameter int T_PED    = 20,
  parameter int T_EM     = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_APP-1:0]   em_req,
`ifdef PED_CALL_EN
  input  logic               ped_call,
`endif
  output logic [2*N_APP-1:0] light,
  output logic [N_APP-1:0]   walk,
  output logic [N_APP-1:0]   buzzer,
  output logic               em_active,
  output logic [1:0]         cur_app
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_GREEN, T_YELLOW), max2(T_CLEAR, T_PED)), T_EM);
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [1:0] LAST = 2'(N_APP - 1);
  localparam logic [1:0] L_G  = 2'b00;
  localparam logic [1:0] L_Y  = 2'b01;
  localparam logic [1:0] L_R  = 2'b10;
  localparam logic [2*N_APP-1:0] LIGHT_RST = {{(N_APP-1){L_R}}, L_G};

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_PED, S_CLEAR} state_t;

  // Lowest set request index wins; returns 0 when nothing is requested.
  function automatic logic [1:0] lowest_set(input logic [N_APP-1:0] req);
    logic [1:0] r;
    r = 2'd0;
    for (int i = N_APP - 1; i >= 0; i--) begin
      if (req[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic req_bit(input logic [N_APP-1:0] req, input logic [1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_APP; i++) begin
      if (idx == 2'(i)) r = req[i];
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] last_tick(input state_t s);
    case (s)
      S_GREEN:  return TW'(T_GREEN - 1);
      S_YELLOW: return TW'(T_YELLOW - 1);
      S_PED:    return TW'(T_PED - 1);
      default:  return TW'(T_CLEAR - 1);
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    app_q, app_d;
  logic          em_q, em_d;
  logic [1:0]    em_app_q, em_app_d;
  logic [TW-1:0] em_timer_q, em_timer_d;
  logic [1:0]    lo;
  logic          ped_ok;
  logic [2*N_APP-1:0] light_d;
  logic [N_APP-1:0]   walk_d, buzzer_d;

`ifdef PED_CALL_EN
  logic ped_latch_q, ped_prev_q, ped_enter;
  assign ped_ok    = ped_latch_q;
  assign ped_enter = (state_d == S_PED) && (state_q != S_PED);

  // A new call during PED (or on its entry edge) is kept for the next round.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_latch_q <= 1'b0;
      ped_prev_q  <= 1'b0;
    end else begin
      ped_prev_q  <= ped_call;
      ped_latch_q <= (ped_latch_q & ~ped_enter) | (ped_call & ~ped_prev_q);
    end
  end
`else
  assign ped_ok = 1'b1;
`endif

  assign lo = lowest_set(em_req);

  // Normal sequence and its timer stay frozen for the whole emergency episode.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    app_d      = app_q;
    em_d       = em_q;
    em_app_d   = em_app_q;
    em_timer_d = em_timer_q;
    if (!em_q) begin
      if (|em_req) begin
        em_d       = 1'b1;
        em_app_d   = lo;
        em_timer_d = '0;
      end else if (timer_q == last_tick(state_q)) begin
        timer_d = '0;
        case (state_q)
          S_GREEN: state_d = S_YELLOW;
          S_YELLOW: begin
            if (app_q == LAST && ped_ok) begin
              state_d = S_PED;
            end else begin
              state_d = S_CLEAR;
              app_d   = (app_q == LAST) ? 2'd0 : app_q + 2'd1;
            end
          end
          S_PED: begin
            state_d = S_CLEAR;
            app_d   = 2'd0;
          end
          default: state_d = S_GREEN;
        endcase
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else begin
      if (|em_req && lo < em_app_q) begin
        em_app_d   = lo;
        em_timer_d = '0;
      end else if (em_timer_q == TW'(T_EM - 1)) begin
        em_timer_d = '0;
        if (!req_bit(em_req, em_app_q)) begin
          if (|em_req) em_app_d = lo;
          else         em_d     = 1'b0;
        end
      end else begin
        em_timer_d = em_timer_q + TW'(1);
      end
    end
  end

  // Outputs are decoded from the next state so the registers line up with the state they describe.
  always_comb begin
    light_d  = '0;
    walk_d   = '0;
    buzzer_d = '0;
    for (int j = 0; j < N_APP; j++) begin
      light_d[2*j +: 2] = L_R;
      if (em_d) begin
        if (em_app_d == 2'(j)) light_d[2*j +: 2] = L_G;
      end else begin
        case (state_d)
          S_GREEN: begin
            if (app_d == 2'(j)) light_d[2*j +: 2] = L_G;
            else                walk_d[j] = 1'b1;
          end
          S_YELLOW: begin
            if (app_d == 2'(j)) light_d[2*j +: 2] = L_Y;
            else                walk_d[j] = 1'b1;
          end
          S_PED: walk_d[j] = 1'b1;
          default: begin
            walk_d[j]   = 1'b1;
            buzzer_d[j] = (app_d == 2'(j));
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_GREEN;
      timer_q    <= '0;
      app_q      <= 2'd0;
      em_q       <= 1'b0;
      em_app_q   <= 2'd0;
      em_timer_q <= '0;
      light      <= LIGHT_RST;
      walk       <= '0;
      buzzer     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      app_q      <= app_d;
      em_q       <= em_d;
      em_app_q   <= em_app_d;
      em_timer_q <= em_timer_d;
      light      <= light_d;
      walk       <= walk_d;
      buzzer     <= buzzer_d;
    end
  end

  assign em_active = em_q;
  assign cur_app   = app_q;

endmodule

// File: tb/tb_multi_approach_signal_controller.sv
// Random emergency-request bench for multi_approach_signal_controller, scored against a phase-list reference model.
module tb_multi_approach_signal_controller;

  localparam int NA = 3;
  localparam int TG = 6;
  localparam int TY = 3;
  localparam int TC = 2;
  localparam int TP = 4;
  localparam int TE = 5;
  localparam int NCYC = 3000;

  logic            clk;
  logic            reset_n;
  logic [NA-1:0]   em_req;
  logic [2*NA-1:0] light;
  logic [NA-1:0]   walk;
  logic [NA-1:0]   buzzer;
  logic            em_active;
  logic [1:0]      cur_app;
`ifdef PED_CALL_EN
  logic            ped_call;
`endif

  multi_approach_signal_controller #(
    .N_APP(NA), .T_GREEN(TG), .T_YELLOW(TY), .T_CLEAR(TC), .T_PED(TP), .T_EM(TE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .em_req(em_req),
`ifdef PED_CALL_EN
    .ped_call(ped_call),
`endif
    .light(light),
    .walk(walk),
    .buzzer(buzzer),
    .em_active(em_active),
    .cur_app(cur_app)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: the round is an explicit list of phases, each counted down in cycles left.
  localparam int K_G = 0, K_Y = 1, K_P = 2, K_C = 3;
  int ph_kind[$];
  int ph_app[$];
  int pos, left;
  bit em_on;
  int em_k, em_left;

  function automatic int dur(input int kind);
    case (kind)
      K_G:     return TG;
      K_Y:     return TY;
      K_P:     return TP;
      default: return TC;
    endcase
  endfunction

  function automatic int lowest(input logic [NA-1:0] r);
    for (int i = 0; i < NA; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic build_round();
    for (int i = 0; i < NA; i++) begin
      ph_kind.push_back(K_G); ph_app.push_back(i);
      ph_kind.push_back(K_Y); ph_app.push_back(i);
`ifndef PED_CALL_EN
      if (i == NA - 1) begin ph_kind.push_back(K_P); ph_app.push_back(i); end
`endif
      ph_kind.push_back(K_C); ph_app.push_back((i + 1) % NA);
    end
  endtask

  task automatic model_reset();
    pos = 0; left = dur(ph_kind[0]);
    em_on = 1'b0; em_k = 0; em_left = 0;
  endtask

  task automatic model_step(input logic [NA-1:0] r);
    int low;
    low = lowest(r);
    if (!em_on) begin
      if (r != 0) begin
        em_on = 1'b1; em_k = low; em_left = TE;
      end else begin
        left--;
        if (left == 0) begin
          pos = (pos + 1) % ph_kind.size();
          left = dur(ph_kind[pos]);
        end
      end
    end else if (r != 0 && low < em_k) begin
      em_k = low; em_left = TE;
    end else begin
      em_left--;
      if (em_left == 0) begin
        if (r[em_k])     em_left = TE;
        else if (r != 0) begin em_k = low; em_left = TE; end
        else             em_on = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    logic [2*NA-1:0] e_light;
    logic [NA-1:0]   e_walk, e_buz;
    int kind, own;
    kind = ph_kind[pos];
    own  = ph_app[pos];
    e_light = '0; e_walk = '0; e_buz = '0;
    for (int j = 0; j < NA; j++) begin
      e_light[2*j +: 2] = 2'b10;
      if (em_on) begin
        if (j == em_k) e_light[2*j +: 2] = 2'b00;
      end else if (kind == K_G || kind == K_Y) begin
        if (j == own) e_light[2*j +: 2] = (kind == K_G) ? 2'b00 : 2'b01;
        else          e_walk[j] = 1'b1;
      end else begin
        e_walk[j] = 1'b1;
        if (kind == K_C && j == own) e_buz[j] = 1'b1;
      end
    end
    check_eq("light",     32'(light),     32'(e_light));
    check_eq("walk",      32'(walk),      32'(e_walk));
    check_eq("buzzer",    32'(buzzer),    32'(e_buz));
    check_eq("em_active", 32'(em_active), 32'(em_on));
    check_eq("cur_app",   32'(cur_app),   32'(own));
  endtask

  task automatic check_reset_state();
    logic [2*NA-1:0] e_light;
    for (int j = 0; j < NA; j++) e_light[2*j +: 2] = (j == 0) ? 2'b00 : 2'b10;
    check_eq("rst_light",  32'(light),     32'(e_light));
    check_eq("rst_walk",   32'(walk),      32'd0);
    check_eq("rst_buzzer", 32'(buzzer),    32'd0);
    check_eq("rst_em",     32'(em_active), 32'd0);
    check_eq("rst_cur",    32'(cur_app),   32'd0);
  endtask

  initial begin
    logic [NA-1:0] req_v;
    int hold;
    req_v = '0;
    hold  = 0;
    reset_n = 1'b0;
    em_req  = '0;
`ifdef PED_CALL_EN
    ped_call = 1'b0;
`endif
    build_round();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 99) < 30) begin
          req_v = NA'($urandom_range(1, (1 << NA) - 1));
          hold  = $urandom_range(1, 12);
        end else begin
          req_v = '0;
          hold  = $urandom_range(1, 40);
        end
      end
      hold--;
      em_req = req_v;
      @(posedge clk);
      model_step(req_v);
      #1;
      check_model();

      // Asynchronous reset in the middle of whatever phase or emergency is active.
      if (cyc == NCYC / 2) begin
        reset_n = 1'b0;
        em_req  = '0;
        req_v   = '0;
        hold    = 0;
        #1;
        check_reset_state();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
